// File: rtl/alu_pkg.sv
// Shared opcode map, control-state encoding and flag bit positions for alu_pipe.
// Flags are packed {N, V, C, Z}, so bit 0 is Z.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_SRL = 4'd2;
   localparam logic [3:0] OP_SLL = 4'd3;
   localparam logic [3:0] OP_ROR = 4'd4;
   localparam logic [3:0] OP_ROL = 4'd5;
   localparam logic [3:0] OP_AND = 4'd6;
   localparam logic [3:0] OP_OR  = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8;
   localparam logic [3:0] OP_XOR = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_SLT = 4'd11;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_t;

   localparam int FLG_Z = 0;
   localparam int FLG_C = 1;
   localparam int FLG_V = 2;
   localparam int FLG_N = 3;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between operand fetch, alu_pipe and writeback.
// master drives operands and out_ready; slave (the ALU) drives results and status.
interface alu_pipe_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f;
   logic [3:0]       flags;
   logic             busy;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, f, flags, busy
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, f, flags, busy
   );

endinterface

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// done is high during the last iteration; product is then the final value (no stall).
module alu_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   // Product is exposed as the accumulator's next value so the caller can
   // capture it on the same edge as the final iteration.
   assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
   assign product = acc_nxt;
   assign done    = (cnt == CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         cnt    <= CW'(WIDTH);
      end else if (cnt != '0) begin
         acc    <= acc_nxt;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with N/V/C/Z flags: latency 1 for single-cycle ops, WIDTH for MUL.
// Accepts only in IDLE with the output register free or draining; results hold while stalled.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_pipe_if.slave  bus
);

   state_t             state_q, state_d;
   logic               out_valid_q;
   logic [WIDTH-1:0]   f_q;
   logic [3:0]         flags_q;
   logic               accept;
   logic               mul_start;
   logic               mul_done;
   logic               mul_fire;
   logic [2*WIDTH-1:0] product;

   logic [SHW-1:0]     s;
   logic [WIDTH:0]     sum, diff, sll_w, srl_w;
   logic [2*WIDTH-1:0] ror_w, rol_w;
   logic [WIDTH-1:0]   ld_f;
   logic               ld_c, ld_v;
   logic [3:0]         ld_flags;

   assign bus.in_ready  = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
   assign bus.out_valid = out_valid_q;
   assign bus.f         = f_q;
   assign bus.flags     = flags_q;
   assign bus.busy      = (state_q == MUL);

   assign accept    = bus.in_valid && bus.in_ready;
   assign mul_start = accept && (bus.op == OP_MUL);
   assign mul_fire  = (state_q == MUL) && mul_done;

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done),
      .product (product)
   );

   // Widened shifts carry the last bit shifted out in their spare bit.
   assign s     = bus.b[SHW-1:0];
   assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
   assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
   assign sll_w = {1'b0, bus.a} << s;
   assign srl_w = {bus.a, 1'b0} >> s;
   assign ror_w = {bus.a, bus.a} >> s;
   assign rol_w = {bus.a, bus.a} << s;

   always_comb begin
      ld_f = '0;
      ld_c = 1'b0;
      ld_v = 1'b0;
      if (state_q == MUL) begin
         ld_f = product[WIDTH-1:0];
         ld_c = |product[2*WIDTH-1:WIDTH];
      end else begin
         case (bus.op)
            OP_ADD: begin
               ld_f = sum[WIDTH-1:0];
               ld_c = sum[WIDTH];
               ld_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
               ld_f = diff[WIDTH-1:0];
               ld_c = diff[WIDTH];
               ld_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SRL: begin
               ld_f = srl_w[WIDTH:1];
               ld_c = srl_w[0];
            end
            OP_SLL: begin
               ld_f = sll_w[WIDTH-1:0];
               ld_c = sll_w[WIDTH];
            end
            OP_ROR:  ld_f = ror_w[WIDTH-1:0];
            OP_ROL:  ld_f = rol_w[2*WIDTH-1:WIDTH];
            OP_AND:  ld_f = bus.a & bus.b;
            OP_OR:   ld_f = bus.a | bus.b;
            OP_NOT:  ld_f = ~bus.a;
            OP_XOR:  ld_f = bus.a ^ bus.b;
            OP_SLT:  ld_f = WIDTH'($signed(bus.a) < $signed(bus.b));
            default: ld_f = '0;
         endcase
      end
      ld_flags        = '0;
      ld_flags[FLG_Z] = (ld_f == '0);
      ld_flags[FLG_C] = ld_c;
      ld_flags[FLG_V] = ld_v;
      ld_flags[FLG_N] = ld_f[WIDTH-1];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mul_start) state_d = MUL;
         MUL:     if (mul_done)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         f_q         <= '0;
         flags_q     <= '0;
      end else if (mul_fire || (accept && !mul_start)) begin
         out_valid_q <= 1'b1;
         f_q         <= ld_f;
         flags_q     <= ld_flags;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8: expected beats queued at issue, checked on transfer.
module tb_alu_pipe;
   import alu_pkg::*;

   typedef struct packed {
      logic [7:0] f;
      logic [3:0] fl;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_beat  = 0;

   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(8)) bus();

   alu_pipe #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      @(negedge clk);
      while (!bus.in_ready && k < 50) begin
         k++;
         @(negedge clk);
      end
      if (!bus.in_ready) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: in_ready got 0 want 1 after 50 cycles", tag);
      end
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      @(negedge clk);
      while (!bus.out_valid && k < 50) begin
         k++;
         @(negedge clk);
      end
      if (!bus.out_valid) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: out_valid got 0 want 1 after 50 cycles", tag);
      end
   endtask

   // Single-cycle op: drive, queue expectation, and confirm the result appears after one edge.
   task automatic issue(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ef, input logic [3:0] efl);
      step();
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      sb.push_back({ef, efl});
      wait_ready(tag);
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd1);
   endtask

   // Every transferred beat must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL beat%0d: got f=%0h flags=%0h want no beat", n_beat, bus.f, bus.flags);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("beat%0d_f", n_beat), 32'(bus.f), 32'(e.f));
            chk($sformatf("beat%0d_flags", n_beat), 32'(bus.flags), 32'(e.fl));
         end
         n_beat++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish within 100us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      bus.out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_f",         32'(bus.f),         32'd0);
      chk("rst_flags",     32'(bus.flags),     32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

      issue("add_ff_01",  OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011);
      issue("sub_05_07",  OP_SUB, 8'h05, 8'h07, 8'hFE, 4'b1010);
      issue("add_ovf",    OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100);
      issue("sub_ovf",    OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0100);
      issue("ror_81_s1",  OP_ROR, 8'h81, 8'h09, 8'hC0, 4'b1000);
      issue("rol_81_s0",  OP_ROL, 8'h81, 8'h00, 8'h81, 4'b1000);
      issue("rol_81_s1",  OP_ROL, 8'h81, 8'h01, 8'h03, 4'b0000);
      issue("sll_81_s1",  OP_SLL, 8'h81, 8'h01, 8'h02, 4'b0010);
      issue("srl_81_s1",  OP_SRL, 8'h81, 8'h01, 8'h40, 4'b0010);
      issue("srl_81_s0",  OP_SRL, 8'h81, 8'h08, 8'h81, 4'b1000);
      issue("and",        OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
      issue("or",         OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b1000);
      issue("not",        OP_NOT, 8'h0F, 8'hAA, 8'hF0, 4'b1000);
      issue("xor_zero",   OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0001);
      issue("slt_80_01",  OP_SLT, 8'h80, 8'h01, 8'h01, 4'b0000);
      issue("slt_01_80",  OP_SLT, 8'h01, 8'h80, 8'h00, 4'b0001);
      issue("op13",       4'd13,  8'h05, 8'h03, 8'h00, 4'b0001);

      // MUL 13*11: busy for 8 cycles, result visible in the 9th.
      step();
      bus.op = OP_MUL; bus.a = 8'd13; bus.b = 8'd11; bus.in_valid = 1'b1;
      sb.push_back({8'h8F, 4'b1000});
      wait_ready("mul_13_11");
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk($sformatf("mul_busy_c%0d", i),     32'(bus.busy),      32'd1);
         chk($sformatf("mul_in_ready_c%0d", i), 32'(bus.in_ready),  32'd0);
         chk($sformatf("mul_out_vld_c%0d", i),  32'(bus.out_valid), 32'd0);
      end
      @(negedge clk);
      chk("mul_out_vld_c9", 32'(bus.out_valid), 32'd1);
      chk("mul_busy_c9",    32'(bus.busy),      32'd0);

      step();
      bus.op = OP_MUL; bus.a = 8'h10; bus.b = 8'h10; bus.in_valid = 1'b1;
      sb.push_back({8'h00, 4'b0011});
      wait_ready("mul_10_10");
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
      wait_valid("mul_10_10_done");

      // Backpressure: ADD result held while a pending XOR waits, then drain-and-accept.
      step();
      bus.out_ready = 1'b0;
      issue("bp_add", OP_ADD, 8'h01, 8'h02, 8'h03, 4'b0000);
      bus.op = OP_XOR; bus.a = 8'hF0; bus.b = 8'h0F; bus.in_valid = 1'b1;
      sb.push_back({8'hFF, 4'b1000});
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp_f_c%0d", i),        32'(bus.f),         32'h03);
         chk($sformatf("bp_out_vld_c%0d", i),  32'(bus.out_valid), 32'd1);
         chk($sformatf("bp_in_ready_c%0d", i), 32'(bus.in_ready),  32'd0);
      end
      step();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_drain", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("bp_xor_out_vld", 32'(bus.out_valid), 32'd1);

      // Reset during MUL cycle 4 aborts it with no result.
      step();
      bus.op = OP_MUL; bus.a = 8'd3; bus.b = 8'd5; bus.in_valid = 1'b1;
      wait_ready("mul_abort");
      @(posedge clk);
      #2;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("abort_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_busy",      32'(bus.busy),      32'd0);
      chk("abort_in_ready",  32'(bus.in_ready),  32'd0);
      chk("abort_f",         32'(bus.f),         32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      chk("abort_no_result", 32'(seen), 32'd0);
      issue("add_after_rst", OP_ADD, 8'h02, 8'h02, 8'h04, 4'b0000);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
